pad_bus_arbiter: RTL and testbench

//  Owns the chip's multiplexed 8-bit pad bus and shares it between two requesters: the CPU core and a DMA/debug port.

---
 rtl/pad_bus_pkg.sv | 14 +
 rtl/pad_rr_arb.sv | 28 ++
 rtl/pad_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_pad_bus_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_bus_pkg.sv
// Shared types and constants for the pad bus arbiter: FSM state, pad phase codes, owner codes.
package pad_bus_pkg;

  typedef enum logic [2:0] {IDLE, ADL, ADH, WDAT, RDAT} state_t;

  localparam logic [1:0] LH_ADL  = 2'd0;
  localparam logic [1:0] LH_ADH  = 2'd1;
  localparam logic [1:0] LH_WDAT = 2'd2;
  localparam logic [1:0] LH_RDAT = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/pad_rr_arb.sv
// Two-way round-robin grant between CPU and DMA; purely combinational.
module pad_rr_arb
  import pad_bus_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic cpu_ack,
  input  logic dma_ack,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  logic cpu_elig;
  logic dma_elig;

  always_comb begin
    // a requester being acked this cycle still shows its old req; ignore it
    cpu_elig    = cpu_req & ~cpu_ack;
    dma_elig    = dma_req & ~dma_ack;
    grant_valid = cpu_elig | dma_elig;
    if (cpu_elig && dma_elig)
      grant_owner = ~last_owner;
    else
      grant_owner = dma_elig ? OWN_DMA : OWN_CPU;
  end

endmodule

// File: rtl/pad_bus_arbiter.sv
// Multiplexed 8-bit pad bus owner: arbitrates CPU/DMA and runs ADL -> ADH -> data phases.
// Optional stall timeout (parameter TIMEOUT) is enabled by defining PADARB_TIMEOUT_EN.
module pad_bus_arbiter
  import pad_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [7:0]  pad_do,
  output logic        pad_oe,
  output logic [1:0]  pad_lh,
  input  logic [7:0]  pad_di,
  input  logic        pad_rdy,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  state_t      state, state_nxt;
  logic        last_owner;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        grant_valid, grant_owner;
  logic        done, abort;

  pad_rr_arb u_arb (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .cpu_ack    (cpu_ack),
    .dma_ack    (dma_ack),
    .last_owner (last_owner),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

`ifdef PADARB_TIMEOUT_EN
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);
  logic [7:0] stall_cnt;
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:       if (grant_valid) state_nxt = ADL;
      ADL:        if (pad_rdy) state_nxt = ADH;
      ADH:        if (pad_rdy) state_nxt = lat_we ? WDAT : RDAT;
      WDAT, RDAT: if (pad_rdy) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                  end
      default:    state_nxt = IDLE;
    endcase
`ifdef PADARB_TIMEOUT_EN
    // this stall cycle is the TIMEOUT-th one in the current phase
    if (state != IDLE && !pad_rdy && stall_cnt == STALL_LAST) begin
      state_nxt = IDLE;
      abort     = 1'b1;
    end
`endif
  end

  always_comb begin
    pad_do = '0;
    pad_lh = LH_ADL;
    pad_oe = 1'b1;
    case (state)
      ADL:  pad_do = lat_addr[7:0];
      ADH:  begin
              pad_do = lat_addr[15:8];
              pad_lh = LH_ADH;
            end
      WDAT: begin
              pad_do = lat_wdata;
              pad_lh = LH_WDAT;
            end
      RDAT: begin
              pad_lh = LH_RDAT;
              pad_oe = 1'b0;
            end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWN_DMA;
      owner      <= OWN_CPU;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      err        <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state   <= state_nxt;
      cpu_ack <= (done | abort) && owner == OWN_CPU;
      dma_ack <= (done | abort) && owner == OWN_DMA;
      err     <= abort;
      if (state == IDLE && grant_valid) begin
        owner      <= grant_owner;
        last_owner <= grant_owner;
        lat_we     <= (grant_owner == OWN_DMA) ? dma_we    : cpu_we;
        lat_addr   <= (grant_owner == OWN_DMA) ? dma_addr  : cpu_addr;
        lat_wdata  <= (grant_owner == OWN_DMA) ? dma_wdata : cpu_wdata;
      end
      if (state == RDAT && done) begin
        if (owner == OWN_DMA) dma_rdata <= pad_di;
        else                  cpu_rdata <= pad_di;
      end
      if (abort && !lat_we) begin
        if (owner == OWN_DMA) dma_rdata <= 8'hFF;
        else                  cpu_rdata <= 8'hFF;
      end
    end
  end

`ifdef PADARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == IDLE || state_nxt != state)
      stall_cnt <= '0;
    else if (!pad_rdy)
      stall_cnt <= stall_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pad_bus_arbiter.sv
// Self-checking bench for pad_bus_arbiter: directed scenarios plus a randomized run against a phase-level model.
module tb_pad_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [7:0]  pad_do;
  logic        pad_oe;
  logic [1:0]  pad_lh;
  logic [7:0]  pad_di = '0;
  logic        pad_rdy = 1'b1;
  logic        owner, busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pad_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .pad_do(pad_do), .pad_oe(pad_oe), .pad_lh(pad_lh), .pad_di(pad_di), .pad_rdy(pad_rdy),
    .owner(owner), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_req = 1'b0; dma_req = 1'b0; pad_rdy = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b0; dma_req = 1'b0; pad_rdy = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cpu_ack, dma_ack, err, busy, owner, pad_oe, pad_lh, pad_do, cpu_rdata, dma_rdata} !== {6'b000001, 2'd0, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got ack=%b%b err=%b busy=%b own=%b oe=%b lh=%0d do=%h rd=%h/%h, want all 0 except oe=1",
               cpu_ack, dma_ack, err, busy, owner, pad_oe, pad_lh, pad_do, cpu_rdata, dma_rdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_cpu_write();
    logic [12:0] exp_v [3];
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A; pad_rdy = 1'b1;
    exp_v = '{ {1'b1, 1'b0, 2'd0, 1'b1, 8'h34},
               {1'b1, 1'b0, 2'd1, 1'b1, 8'h12},
               {1'b1, 1'b0, 2'd2, 1'b1, 8'h5A} };
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({busy, owner, pad_lh, pad_oe, pad_do} !== exp_v[c] || cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL cpu_write_phase%0d: got busy/own/lh/oe/do=%h ack=%b, want %h ack=0",
                 c + 1, {busy, owner, pad_lh, pad_oe, pad_do}, cpu_ack, exp_v[c]);
      end
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_write_ack: got cpu_ack=%b dma_ack=%b err=%b busy=%b, want 1 0 0 0", cpu_ack, dma_ack, err, busy);
    end
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cpu_write_ack_pulse: got cpu_ack=%b busy=%b, want 0 0", cpu_ack, busy);
    end
  endtask

  task automatic test_dma_read_wait();
    logic [1:0] exp_lh  [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    logic [7:0] exp_do  [5] = '{8'hEF, 8'hBE, 8'hBE, 8'hBE, 8'h00};
    logic       exp_oe  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       rdy     [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'hBEEF; pad_di = 8'hC3; pad_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || owner !== 1'b1 || pad_lh !== exp_lh[c] || pad_do !== exp_do[c] || pad_oe !== exp_oe[c]) begin
        errors++;
        $display("FAIL dma_read_cycle%0d: got busy=%b own=%b lh=%0d do=%h oe=%b, want 1 1 %0d %h %b",
                 c + 1, busy, owner, pad_lh, pad_do, pad_oe, exp_lh[c], exp_do[c], exp_oe[c]);
      end
      pad_rdy = rdy[c];
    end
    tick();
    checks++;
    if (dma_ack !== 1'b1 || cpu_ack !== 1'b0 || dma_rdata !== 8'hC3 || err !== 1'b0) begin
      errors++;
      $display("FAIL dma_read_ack: got dma_ack=%b cpu_ack=%b rdata=%h err=%b, want 1 0 c3 0", dma_ack, cpu_ack, dma_rdata, err);
    end
    dma_req = 1'b0; pad_di = 8'h00;
    tick();
  endtask

  // runs straight after test_dma_read_wait, so dma_rdata holds C3 going in
  task automatic test_reset_mid_transfer();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0F0F; cpu_wdata = 8'h77; pad_rdy = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (pad_lh !== 2'd2 || pad_do !== 8'h77) begin
      errors++;
      $display("FAIL reset_mid_setup: got lh=%0d do=%h, want 2 77", pad_lh, pad_do);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pad_oe !== 1'b1 || pad_lh !== 2'd0 || cpu_ack !== 1'b0 || dma_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_state: got busy=%b oe=%b lh=%0d ack=%b dma_rdata=%h, want 0 1 0 0 00",
               busy, pad_oe, pad_lh, cpu_ack, dma_rdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; cpu_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_ack: got acks=%b%b busy=%b, want 00 0", cpu_ack, dma_ack, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic exp_own [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic prev = 1'b1;
    int   n;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1111; cpu_wdata = 8'h22;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h3333; pad_rdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      do begin tick(); n++; end while (busy !== 1'b1 && n < 10);
      checks++;
      if (busy !== 1'b1 || owner !== exp_own[t] || (t > 0 && owner === prev)) begin
        errors++;
        $display("FAIL rr_grant%0d: got busy=%b owner=%b prev=%b, want busy=1 owner=%b", t, busy, owner, prev, exp_own[t]);
      end
      prev = owner;
      n = 0;
      do begin tick(); n++; end while (cpu_ack !== 1'b1 && dma_ack !== 1'b1 && n < 10);
      checks++;
      if ({cpu_ack, dma_ack} !== (exp_own[t] ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rr_ack%0d: got cpu_ack/dma_ack=%b%b, want %b", t, cpu_ack, dma_ack, exp_own[t] ? 2'b01 : 2'b10);
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
  endtask

  task automatic test_ack_hold();
    int n;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA0A0; cpu_wdata = 8'h01; pad_rdy = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL hold_ack: got cpu_ack=%b, want 1", cpu_ack);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_regrant: got busy=%b, want 0", busy);
    end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick(); tick();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h5555;
    tick(); tick();
    checks++;
    if (cpu_ack !== 1'b1 || owner !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack2: got cpu_ack=%b owner=%b, want 1 0", cpu_ack, owner);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || owner !== 1'b1) begin
      errors++;
      $display("FAIL hold_dma_next: got busy=%b owner=%b, want 1 1", busy, owner);
    end
    cpu_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (dma_ack !== 1'b1 && n < 10);
    checks++;
    if (dma_ack !== 1'b1) begin
      errors++;
      $display("FAIL hold_dma_ack: got dma_ack=%b, want 1", dma_ack);
    end
    dma_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle_after: got busy=%b, want 0", busy);
    end
  endtask

`ifdef PADARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4242; pad_rdy = 1'b1;
    tick();
    pad_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy !== 1'b1 || pad_lh !== 2'd0 || cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL timeout_stall%0d: got busy=%b lh=%0d ack=%b, want 1 0 0", c, busy, pad_lh, cpu_ack);
      end
      tick();
    end
    checks++;
    if (cpu_ack !== 1'b1 || err !== 1'b1 || cpu_rdata !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got ack=%b err=%b rdata=%h busy=%b, want 1 1 ff 0", cpu_ack, err, cpu_rdata, busy);
    end
    cpu_req = 1'b0; pad_rdy = 1'b1;
    tick();
  endtask
`endif

  // model tracks each transfer as a phase index 0..2 and applies the arbitration rules directly
  task automatic test_random();
    logic       m_busy = 1'b0, m_own = 1'b0, m_last = 1'b1, m_we = 1'b0;
    int         m_ph = 0;
    logic [15:0] m_addr = '0;
    logic [7:0] m_wd = '0, m_rd_c = '0, m_rd_d = '0;
    logic       m_ack_c = 1'b0, m_ack_d = 1'b0, n_ack_c, n_ack_d, c_el, d_el;
    logic [1:0] e_lh;
    logic [7:0] e_do;
    logic       e_oe;
    int         stalls = 0, grants = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      e_lh = 2'd0; e_do = 8'h00; e_oe = 1'b1;
      if (m_busy) begin
        if (m_ph == 0) e_do = m_addr[7:0];
        else if (m_ph == 1) begin e_lh = 2'd1; e_do = m_addr[15:8]; end
        else begin e_lh = m_we ? 2'd2 : 2'd3; e_do = m_we ? m_wd : 8'h00; e_oe = m_we; end
      end
      checks++;
      if (busy !== m_busy || (m_busy && owner !== m_own) || pad_lh !== e_lh || pad_do !== e_do || pad_oe !== e_oe) begin
        errors++;
        $display("FAIL rand_pad cyc%0d: got busy=%b own=%b lh=%0d do=%h oe=%b, want %b %b %0d %h %b",
                 cyc, busy, owner, pad_lh, pad_do, pad_oe, m_busy, m_own, e_lh, e_do, e_oe);
      end
      checks++;
      if (cpu_ack !== m_ack_c || dma_ack !== m_ack_d || err !== 1'b0 || cpu_rdata !== m_rd_c || dma_rdata !== m_rd_d) begin
        errors++;
        $display("FAIL rand_ack cyc%0d: got ack=%b%b err=%b rd=%h/%h, want %b%b 0 %h/%h",
                 cyc, cpu_ack, dma_ack, err, cpu_rdata, dma_rdata, m_ack_c, m_ack_d, m_rd_c, m_rd_d);
      end
      // requesters: drop (or briefly keep a stale req) on ack, otherwise raise new work at random
      if (m_ack_c) begin
        if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      end
      if (m_ack_d) begin
        if ($urandom_range(0, 1) == 0) dma_req = 1'b0;
      end else if (!dma_req && $urandom_range(0, 3) == 0) begin
        dma_req = 1'b1; dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
      end
      if (m_busy && $urandom_range(0, 3) == 0) begin
        if (m_own) begin dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom); end
        else       begin cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); end
      end
      pad_di  = 8'($urandom);
      pad_rdy = (stalls >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      stalls  = pad_rdy ? 0 : stalls + 1;

      n_ack_c = 1'b0; n_ack_d = 1'b0;
      if (m_busy) begin
        if (pad_rdy) begin
          if (m_ph == 2) begin
            m_busy = 1'b0;
            if (m_own) begin n_ack_d = 1'b1; if (!m_we) m_rd_d = pad_di; end
            else       begin n_ack_c = 1'b1; if (!m_we) m_rd_c = pad_di; end
          end else begin
            m_ph++;
          end
        end
      end else begin
        c_el = cpu_req && !m_ack_c;
        d_el = dma_req && !m_ack_d;
        if (c_el || d_el) begin
          m_own  = (c_el && d_el) ? !m_last : d_el;
          m_last = m_own;
          m_busy = 1'b1;
          m_ph   = 0;
          grants++;
          m_we   = m_own ? dma_we    : cpu_we;
          m_addr = m_own ? dma_addr  : cpu_addr;
          m_wd   = m_own ? dma_wdata : cpu_wdata;
        end
      end
      m_ack_c = n_ack_c; m_ack_d = n_ack_d;
      tick();
    end
    checks++;
    if (grants < 100) begin
      errors++;
      $display("FAIL rand_activity: got %0d grants, want at least 100", grants);
    end
    cpu_req = 1'b0; dma_req = 1'b0; pad_rdy = 1'b1;
    tick(); tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_dma_read_wait();
    test_reset_mid_transfer();
    test_round_robin();
    test_ack_hold();
`ifdef PADARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
